// File: rtl/uart_pkg.sv
// Shared UART types and helpers used by the transmitter and, later, the receiver.
package uart_pkg;

   typedef enum logic [1:0] {
      PAR_NONE = 2'b00,
      PAR_EVEN = 2'b01,
      PAR_ODD  = 2'b10,
      PAR_RSVD = 2'b11
   } parity_mode_t;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } tx_state_t;

   localparam int DEFAULT_BAUD_DIV = 1042;
   localparam int MAX_DATA_BITS    = 9;

   function automatic logic parity_enabled(input parity_mode_t mode);
      return (mode == PAR_EVEN) || (mode == PAR_ODD);
   endfunction

   // Narrower payloads are zero-extended by the caller, which leaves the XOR unchanged.
   function automatic logic calc_parity(input logic [MAX_DATA_BITS-1:0] data,
                                        input parity_mode_t mode);
      logic p;
      case (mode)
         PAR_ODD: p = ~(^data);
         default: p = ^data;
      endcase
      return p;
   endfunction

endpackage

// File: rtl/uart_tx_param_if.sv
// Upstream handshake and serial-side signals of the parametrised UART transmitter.
interface uart_tx_param_if #(parameter int DATA_BITS = 8);
   logic [DATA_BITS-1:0] tx_data_i;
   logic [1:0]           parity_mode_i;
   logic                 tx_valid_i;
   logic                 tx_ready_o;
   logic                 tx_o;
   logic                 busy_o;
   logic                 frame_done_o;

   modport master (
      output tx_data_i, parity_mode_i, tx_valid_i,
      input  tx_ready_o, tx_o, busy_o, frame_done_o
   );

   modport slave (
      input  tx_data_i, parity_mode_i, tx_valid_i,
      output tx_ready_o, tx_o, busy_o, frame_done_o
   );
endinterface

// File: rtl/uart_baud_gen.sv
// Bit-period timer: counts 0..BAUD_DIV-1 while enabled and flags the last count.
module uart_baud_gen
   import uart_pkg::*;
#(
   parameter int BAUD_DIV = DEFAULT_BAUD_DIV
) (
   input  logic clk,
   input  logic nrst,
   input  logic en,
   input  logic clear,
   output logic tick
);

   localparam int            CW   = $clog2(BAUD_DIV);
   localparam logic [CW-1:0] LAST = CW'(BAUD_DIV - 1);

   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clear || !en) begin
         cnt_d = '0;
      end else if (cnt_q == LAST) begin
         cnt_d = '0;
      end else begin
         cnt_d = cnt_q + CW'(1);
      end
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign tick = en & (cnt_q == LAST);

endmodule

// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter: valid/ready intake, optional parity, 1 or 2 stop bits.
module uart_tx_param
   import uart_pkg::*;
#(
   parameter int BAUD_DIV  = DEFAULT_BAUD_DIV,
   parameter int DATA_BITS = 8,
   parameter int STOP_BITS = 1
) (
   input logic             clk,
   input logic             nrst,
   uart_tx_param_if.slave  bus
);

   localparam int             BCW      = $clog2(DATA_BITS);
   localparam logic [BCW-1:0] BIT_LAST = BCW'(DATA_BITS - 1);
   localparam logic           STP_LAST = 1'(STOP_BITS - 1);

   tx_state_t            state_q, state_d;
   logic [BCW-1:0]       bit_cnt_q, bit_cnt_d;
   logic                 stop_cnt_q, stop_cnt_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic                 par_q, par_d;
   logic                 par_en_q, par_en_d;
   logic                 tx_q, tx_d;
   logic                 tick_s;
   logic                 accept_s;
   logic                 done_s;
   parity_mode_t         mode_s;

   assign mode_s   = parity_mode_t'(bus.parity_mode_i);
   assign accept_s = (state_q == IDLE) & bus.tx_valid_i;

   uart_baud_gen #(.BAUD_DIV(BAUD_DIV)) u_baud (
      .clk   (clk),
      .nrst  (nrst),
      .en    (state_q != IDLE),
      .clear (accept_s),
      .tick  (tick_s)
   );

   // tx_d is the value the line takes for the bit that begins after this edge.
   always_comb begin
      state_d    = state_q;
      bit_cnt_d  = bit_cnt_q;
      stop_cnt_d = stop_cnt_q;
      shift_d    = shift_q;
      par_d      = par_q;
      par_en_d   = par_en_q;
      tx_d       = tx_q;
      done_s     = 1'b0;
      case (state_q)
         IDLE: begin
            tx_d = 1'b1;
            if (accept_s) begin
               shift_d   = bus.tx_data_i;
               par_d     = calc_parity(MAX_DATA_BITS'(bus.tx_data_i), mode_s);
               par_en_d  = parity_enabled(mode_s);
               bit_cnt_d = '0;
               tx_d      = 1'b0;
               state_d   = START;
            end else begin
               state_d = IDLE;
            end
         end
         START: begin
            if (tick_s) begin
               tx_d    = shift_q[0];
               state_d = DATA;
            end else begin
               state_d = START;
            end
         end
         DATA: begin
            if (tick_s && (bit_cnt_q == BIT_LAST)) begin
               if (par_en_q) begin
                  tx_d    = par_q;
                  state_d = PARITY;
               end else begin
                  tx_d       = 1'b1;
                  stop_cnt_d = 1'b0;
                  state_d    = STOP;
               end
            end else if (tick_s) begin
               shift_d   = shift_q >> 1;
               tx_d      = shift_q[1];
               bit_cnt_d = bit_cnt_q + BCW'(1);
            end else begin
               state_d = DATA;
            end
         end
         PARITY: begin
            if (tick_s) begin
               tx_d       = 1'b1;
               stop_cnt_d = 1'b0;
               state_d    = STOP;
            end else begin
               state_d = PARITY;
            end
         end
         STOP: begin
            if (tick_s && (stop_cnt_q == STP_LAST)) begin
               done_s  = 1'b1;
               state_d = IDLE;
            end else if (tick_s) begin
               stop_cnt_d = stop_cnt_q + 1'b1;
            end else begin
               state_d = STOP;
            end
         end
         default: begin
            tx_d    = 1'b1;
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state_q    <= IDLE;
         bit_cnt_q  <= '0;
         stop_cnt_q <= 1'b0;
         shift_q    <= '0;
         par_q      <= 1'b0;
         par_en_q   <= 1'b0;
         tx_q       <= 1'b1;
      end else begin
         state_q    <= state_d;
         bit_cnt_q  <= bit_cnt_d;
         stop_cnt_q <= stop_cnt_d;
         shift_q    <= shift_d;
         par_q      <= par_d;
         par_en_q   <= par_en_d;
         tx_q       <= tx_d;
      end
   end

   assign bus.tx_o         = tx_q;
   assign bus.tx_ready_o   = (state_q == IDLE);
   assign bus.busy_o       = (state_q != IDLE);
   assign bus.frame_done_o = done_s;

endmodule

// File: tb/tb_uart_tx_param.sv
// Bench for uart_tx_param: fixed frame vectors, hand-written corner sequences, random frames vs a bit-list model.
module tb_uart_tx_param;

   localparam int BD = 4;

   logic       clk = 1'b0;
   logic       nrst = 1'b1;
   logic       sel_r = 1'b0;
   logic [8:0] data_r = 9'h000;
   logic [1:0] mode_r = 2'b00;
   logic       valid_r = 1'b0;
   int         n_checks = 0;
   int         n_fail = 0;

   uart_tx_param_if #(.DATA_BITS(8)) ifa ();
   uart_tx_param_if #(.DATA_BITS(5)) ifb ();

   assign ifa.tx_data_i     = data_r[7:0];
   assign ifa.parity_mode_i = mode_r;
   assign ifa.tx_valid_i    = valid_r & ~sel_r;
   assign ifb.tx_data_i     = data_r[4:0];
   assign ifb.parity_mode_i = mode_r;
   assign ifb.tx_valid_i    = valid_r & sel_r;

   uart_tx_param #(.BAUD_DIV(BD), .DATA_BITS(8), .STOP_BITS(1)) dut_a (
      .clk(clk), .nrst(nrst), .bus(ifa)
   );
   uart_tx_param #(.BAUD_DIV(BD), .DATA_BITS(5), .STOP_BITS(2)) dut_b (
      .clk(clk), .nrst(nrst), .bus(ifb)
   );

   wire tx_s    = sel_r ? ifb.tx_o         : ifa.tx_o;
   wire ready_s = sel_r ? ifb.tx_ready_o   : ifa.tx_ready_o;
   wire busy_s  = sel_r ? ifb.busy_o       : ifa.busy_o;
   wire done_s  = sel_r ? ifb.frame_done_o : ifa.frame_done_o;

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: the frame as an ordered list of line bits, parity from the count of ones.
   task automatic build_bits(input logic sel, input logic [8:0] data, input logic [1:0] mode,
                             output logic [11:0] bits, output int n);
      int db = sel ? 5 : 8;
      int sb = sel ? 2 : 1;
      int ones = 0;
      bits = '1;
      n = 0;
      bits[n] = 1'b0; n++;
      for (int i = 0; i < db; i++) begin
         bits[n] = data[i]; n++;
         if (data[i]) ones++;
      end
      if (mode == 2'b01) begin
         bits[n] = ((ones % 2) == 1); n++;
      end else if (mode == 2'b10) begin
         bits[n] = ((ones % 2) == 0); n++;
      end
      for (int s = 0; s < sb; s++) begin
         bits[n] = 1'b1; n++;
      end
   endtask

   task automatic wait_ready();
      int k = 0;
      while (!ready_s && k < 200) begin
         @(negedge clk);
         k++;
      end
      chk("ready_timeout", {31'd0, ready_s}, 32'd1);
   endtask

   // Called at the negedge of the first frame cycle; returns at the negedge of the idle cycle after it.
   task automatic expect_frame(input logic [11:0] bits, input int nbits,
                               input bit hold, input logic [8:0] nxt);
      int len = nbits * BD;
      for (int c = 1; c <= len; c++) begin
         if (hold && c == 2) data_r = 9'h1FF;
         if (hold && c == len - 1) data_r = nxt;
         chk("tx_bit", {31'd0, tx_s}, {31'd0, bits[(c-1)/BD]});
         chk("frame_done", {31'd0, done_s}, {31'd0, (c == len)});
         if (c == 1 || c == len) chk("busy_in_frame", {31'd0, busy_s}, 32'd1);
         @(negedge clk);
      end
      chk("ready_after", {31'd0, ready_s}, 32'd1);
      chk("busy_after", {31'd0, busy_s}, 32'd0);
      chk("tx_idle_after", {31'd0, tx_s}, 32'd1);
   endtask

   task automatic send(input logic sel, input logic [8:0] data, input logic [1:0] mode,
                       input logic [11:0] bits, input int nbits);
      sel_r = sel;
      wait_ready();
      chk("tx_idle_before", {31'd0, tx_s}, 32'd1);
      data_r  = data;
      mode_r  = mode;
      valid_r = 1'b1;
      @(negedge clk);
      valid_r = 1'b0;
      data_r  = ~data;
      mode_r  = ~mode;
      expect_frame(bits, nbits, 1'b0, 9'h000);
   endtask

   typedef struct {
      logic        sel;
      logic [8:0]  data;
      logic [1:0]  mode;
      logic [11:0] exp_bits;
      int          exp_nbits;
   } vec_t;

   vec_t vecs[9];

   initial begin
      logic [11:0] bits;
      int          n;

      vecs[0] = '{1'b0, 9'h0A5, 2'b00, 12'h34A, 10};
      vecs[1] = '{1'b0, 9'h007, 2'b01, 12'h60E, 11};
      vecs[2] = '{1'b0, 9'h007, 2'b10, 12'h40E, 11};
      vecs[3] = '{1'b1, 9'h01F, 2'b00, 12'h0FE, 8};
      vecs[4] = '{1'b0, 9'h080, 2'b11, 12'h300, 10};
      vecs[5] = '{1'b0, 9'h080, 2'b00, 12'h300, 10};
      vecs[6] = '{1'b0, 9'h000, 2'b01, 12'h400, 11};
      vecs[7] = '{1'b0, 9'h000, 2'b10, 12'h600, 11};
      vecs[8] = '{1'b1, 9'h015, 2'b10, 12'h1AA, 9};

      #2 nrst = 1'b0;
      #1;
      chk("rst_tx", {31'd0, ifa.tx_o}, 32'd1);
      chk("rst_ready", {31'd0, ifa.tx_ready_o}, 32'd1);
      chk("rst_busy", {31'd0, ifa.busy_o}, 32'd0);
      chk("rst_done", {31'd0, ifa.frame_done_o}, 32'd0);
      chk("rst_ready_b", {31'd0, ifb.tx_ready_o}, 32'd1);
      @(negedge clk);
      @(negedge clk);
      nrst = 1'b1;
      @(negedge clk);

      for (int v = 0; v < 9; v++) begin
         send(vecs[v].sel, vecs[v].data, vecs[v].mode, vecs[v].exp_bits, vecs[v].exp_nbits);
      end

      // Back-to-back with valid held and the data bus disturbed mid-frame.
      sel_r = 1'b0;
      wait_ready();
      data_r  = 9'h011;
      mode_r  = 2'b00;
      valid_r = 1'b1;
      @(negedge clk);
      build_bits(1'b0, 9'h011, 2'b00, bits, n);
      expect_frame(bits, n, 1'b1, 9'h022);
      @(negedge clk);
      valid_r = 1'b0;
      build_bits(1'b0, 9'h022, 2'b00, bits, n);
      expect_frame(bits, n, 1'b0, 9'h000);

      // Reset during data bit 3 (cycles 17..20 of the frame).
      wait_ready();
      data_r  = 9'h052;
      mode_r  = 2'b00;
      valid_r = 1'b1;
      @(negedge clk);
      valid_r = 1'b0;
      repeat (17) @(negedge clk);
      chk("mid_bit3_low", {31'd0, ifa.tx_o}, 32'd0);
      #1 nrst = 1'b0;
      #1;
      chk("abort_tx", {31'd0, ifa.tx_o}, 32'd1);
      chk("abort_ready", {31'd0, ifa.tx_ready_o}, 32'd1);
      chk("abort_busy", {31'd0, ifa.busy_o}, 32'd0);
      chk("abort_done", {31'd0, ifa.frame_done_o}, 32'd0);
      @(negedge clk);
      nrst = 1'b1;
      build_bits(1'b0, 9'h03C, 2'b00, bits, n);
      send(1'b0, 9'h03C, 2'b00, bits, n);

      // Random frames on both configurations.
      for (int r = 0; r < 24; r++) begin
         logic       s;
         logic [8:0] d;
         logic [1:0] m;
         s = (r % 3 == 2);
         d = 9'($urandom_range(0, 511));
         m = 2'($urandom_range(0, 3));
         build_bits(s, d, m, bits, n);
         send(s, d, m, bits, n);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
